// File: rtl/vreg_diff_arbiter.sv
// ---------------------------------------------------------------------------
// vreg_diff_arbiter
//
// Purpose:
//   Shares the single vector-register difftest sink between two requesters
//   (req0 = writeback path, req1 = store path). Each requester streams one
//   register group as 1..8 VLEN-wide beats. The beats are collected into an
//   8-segment buffer, the group is checked, and then exactly one cycle of
//   either dpi_enable (good packet) or err_valid (bad packet) is produced.
//   Arbitration is round-robin and a grant is held for a whole packet.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   reqN_valid/ready      beat handshake (N = 0,1)
//   reqN_is_store, reqN_wr_rf, reqN_rf_addr, reqN_group_size
//                         packet header, sampled on the first beat only
//   reqN_last             final beat of the packet
//   reqN_data             beat payload (VLEN bits)
//   dpi_enable            one-cycle call strobe to the sink
//   dpi_is_store, dpi_wr_rf, dpi_rf_addr, dpi_rf_group_size, dpi_data_0..7
//                         sink fields, meaningful only while dpi_enable = 1
//   busy                  packet in progress (state != IDLE)
//   err_valid, err_code   one-cycle error strobe; 1 = bad header,
//                         2 = beat count mismatch, 3 = overrun
//
// Optional feature (macro VREG_DIFF_ARB_STATS_EN):
//   Adds saturating counters issue_cnt0, issue_cnt1 (32 bit) and
//   err_cnt (16 bit).
// ---------------------------------------------------------------------------
module vreg_diff_arbiter #(
    parameter int VLEN = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_is_store,
    input  logic            req0_wr_rf,
    input  logic [7:0]      req0_rf_addr,
    input  logic [7:0]      req0_group_size,
    input  logic            req0_last,
    input  logic [VLEN-1:0] req0_data,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_is_store,
    input  logic            req1_wr_rf,
    input  logic [7:0]      req1_rf_addr,
    input  logic [7:0]      req1_group_size,
    input  logic            req1_last,
    input  logic [VLEN-1:0] req1_data,
    output logic            dpi_enable,
    output logic            dpi_is_store,
    output logic            dpi_wr_rf,
    output logic [7:0]      dpi_rf_addr,
    output logic [7:0]      dpi_rf_group_size,
    output logic [VLEN-1:0] dpi_data_0,
    output logic [VLEN-1:0] dpi_data_1,
    output logic [VLEN-1:0] dpi_data_2,
    output logic [VLEN-1:0] dpi_data_3,
    output logic [VLEN-1:0] dpi_data_4,
    output logic [VLEN-1:0] dpi_data_5,
    output logic [VLEN-1:0] dpi_data_6,
    output logic [VLEN-1:0] dpi_data_7,
    output logic            busy,
    output logic            err_valid,
    output logic [1:0]      err_code
`ifdef VREG_DIFF_ARB_STATS_EN
    ,
    output logic [31:0]     issue_cnt0,
    output logic [31:0]     issue_cnt1,
    output logic [15:0]     err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, ISSUE} state_t;

    state_t          state, state_next;
    logic            rr;          // 0 favours req0, 1 favours req1
    logic            owner;
    logic            hdr_is_store, hdr_wr_rf;
    logic [7:0]      hdr_addr, hdr_size;
    logic [3:0]      beat_cnt;    // beats stored so far, 1..8
    logic            overrun;
    logic [VLEN-1:0] seg [8];

    logic            grant_valid, grant_sel, sel;
    logic            cur_valid, cur_last, cur_ready, accept;
    logic            cur_is_store, cur_wr_rf;
    logic [7:0]      cur_addr, cur_size;
    logic [VLEN-1:0] cur_data;
    logic            header_bad;
    logic [1:0]      issue_code;

    // Round-robin grant: the favoured requester wins if valid, otherwise
    // the other one may take the slot.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_sel   = rr;
        if (rr == 1'b0) begin
            grant_sel = req0_valid ? 1'b0 : 1'b1;
        end else begin
            grant_sel = req1_valid ? 1'b1 : 1'b0;
        end
    end

    // In IDLE the fresh grant selects the source; afterwards the latched
    // owner does, so the non-owner is ignored for the whole packet.
    always_comb begin
        sel          = (state == IDLE) ? grant_sel : owner;
        cur_valid    = sel ? req1_valid    : req0_valid;
        cur_last     = sel ? req1_last     : req0_last;
        cur_data     = sel ? req1_data     : req0_data;
        cur_is_store = sel ? req1_is_store : req0_is_store;
        cur_wr_rf    = sel ? req1_wr_rf    : req0_wr_rf;
        cur_addr     = sel ? req1_rf_addr  : req0_rf_addr;
        cur_size     = sel ? req1_group_size : req0_group_size;
        cur_ready    = 1'b0;
        case (state)
            IDLE:          cur_ready = grant_valid;
            COLLECT, DRAIN: cur_ready = 1'b1;
            default:       cur_ready = 1'b0;
        endcase
        accept     = cur_ready & cur_valid;
        req0_ready = cur_ready & ~sel;
        req1_ready = cur_ready & sel;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = cur_last ? ISSUE : COLLECT;
            end
            COLLECT: begin
                if (accept) begin
                    if (cur_last)               state_next = ISSUE;
                    else if (beat_cnt == 4'd7)  state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && cur_last) state_next = ISSUE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Packet check in priority order overrun, header, count. The header
    // alignment test relies on group_size being a power of two, and any
    // non-power-of-two size is already flagged by the membership test.
    always_comb begin
        header_bad = !(hdr_size == 8'd1 || hdr_size == 8'd2 ||
                       hdr_size == 8'd4 || hdr_size == 8'd8) ||
                     (hdr_addr >= 8'd32) ||
                     ((hdr_addr & (hdr_size - 8'd1)) != 8'd0);
        if (overrun)                          issue_code = 2'd3;
        else if (header_bad)                  issue_code = 2'd1;
        else if ({4'd0, beat_cnt} != hdr_size) issue_code = 2'd2;
        else                                  issue_code = 2'd0;
    end

    // Outputs. Because the buffer is cleared on the first beat and a good
    // packet has exactly group_size beats, segments beyond the group read 0.
    always_comb begin
        busy              = (state != IDLE);
        dpi_enable        = (state == ISSUE) && (issue_code == 2'd0);
        err_valid         = (state == ISSUE) && (issue_code != 2'd0);
        err_code          = err_valid ? issue_code : 2'd0;
        dpi_is_store      = hdr_is_store;
        dpi_wr_rf         = hdr_wr_rf;
        dpi_rf_addr       = hdr_addr;
        dpi_rf_group_size = hdr_size;
        dpi_data_0        = seg[0];
        dpi_data_1        = seg[1];
        dpi_data_2        = seg[2];
        dpi_data_3        = seg[3];
        dpi_data_4        = seg[4];
        dpi_data_5        = seg[5];
        dpi_data_6        = seg[6];
        dpi_data_7        = seg[7];
    end

    // State register plus packet datapath (header, buffer, beat count).
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr           <= 1'b0;
            owner        <= 1'b0;
            hdr_is_store <= 1'b0;
            hdr_wr_rf    <= 1'b0;
            hdr_addr     <= 8'd0;
            hdr_size     <= 8'd0;
            beat_cnt     <= 4'd0;
            overrun      <= 1'b0;
            for (int k = 0; k < 8; k++) seg[k] <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner        <= grant_sel;
                        hdr_is_store <= cur_is_store;
                        hdr_wr_rf    <= cur_wr_rf;
                        hdr_addr     <= cur_addr;
                        hdr_size     <= cur_size;
                        beat_cnt     <= 4'd1;
                        overrun      <= 1'b0;
                        for (int k = 1; k < 8; k++) seg[k] <= '0;
                        seg[0]       <= cur_data;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        seg[beat_cnt[2:0]] <= cur_data;
                        beat_cnt           <= beat_cnt + 4'd1;
                        if (!cur_last && beat_cnt == 4'd7) overrun <= 1'b1;
                    end
                end
                ISSUE: rr <= ~owner;
                default: ;
            endcase
        end
    end

`ifdef VREG_DIFF_ARB_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt0 <= 32'd0;
            issue_cnt1 <= 32'd0;
            err_cnt    <= 16'd0;
        end else begin
            if (dpi_enable && !owner && issue_cnt0 != 32'hFFFF_FFFF)
                issue_cnt0 <= issue_cnt0 + 32'd1;
            if (dpi_enable && owner && issue_cnt1 != 32'hFFFF_FFFF)
                issue_cnt1 <= issue_cnt1 + 32'd1;
            if (err_valid && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vreg_diff_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vreg_diff_arbiter
//
// Purpose:
//   Directed self-checking bench for vreg_diff_arbiter. Inputs are driven
//   1 time unit after the rising edge and outputs are sampled away from it.
// ---------------------------------------------------------------------------
module tb_vreg_diff_arbiter;

    localparam int VLEN = 1024;

    logic            clk = 1'b0;
    logic            reset;
    logic            req0_valid, req0_ready, req0_is_store, req0_wr_rf, req0_last;
    logic [7:0]      req0_rf_addr, req0_group_size;
    logic [VLEN-1:0] req0_data;
    logic            req1_valid, req1_ready, req1_is_store, req1_wr_rf, req1_last;
    logic [7:0]      req1_rf_addr, req1_group_size;
    logic [VLEN-1:0] req1_data;
    logic            dpi_enable, dpi_is_store, dpi_wr_rf;
    logic [7:0]      dpi_rf_addr, dpi_rf_group_size;
    logic [VLEN-1:0] dpi_data_0, dpi_data_1, dpi_data_2, dpi_data_3;
    logic [VLEN-1:0] dpi_data_4, dpi_data_5, dpi_data_6, dpi_data_7;
    logic            busy, err_valid;
    logic [1:0]      err_code;
`ifdef VREG_DIFF_ARB_STATS_EN
    logic [31:0]     issue_cnt0, issue_cnt1;
    logic [15:0]     err_cnt;
`endif

    int num_checks = 0;
    int num_fails  = 0;

    always #5 clk = ~clk;

    vreg_diff_arbiter #(.VLEN(VLEN)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_is_store(req0_is_store), .req0_wr_rf(req0_wr_rf),
        .req0_rf_addr(req0_rf_addr), .req0_group_size(req0_group_size),
        .req0_last(req0_last), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_is_store(req1_is_store), .req1_wr_rf(req1_wr_rf),
        .req1_rf_addr(req1_rf_addr), .req1_group_size(req1_group_size),
        .req1_last(req1_last), .req1_data(req1_data),
        .dpi_enable(dpi_enable), .dpi_is_store(dpi_is_store),
        .dpi_wr_rf(dpi_wr_rf), .dpi_rf_addr(dpi_rf_addr),
        .dpi_rf_group_size(dpi_rf_group_size),
        .dpi_data_0(dpi_data_0), .dpi_data_1(dpi_data_1),
        .dpi_data_2(dpi_data_2), .dpi_data_3(dpi_data_3),
        .dpi_data_4(dpi_data_4), .dpi_data_5(dpi_data_5),
        .dpi_data_6(dpi_data_6), .dpi_data_7(dpi_data_7),
        .busy(busy), .err_valid(err_valid), .err_code(err_code)
`ifdef VREG_DIFF_ARB_STATS_EN
        , .issue_cnt0(issue_cnt0), .issue_cnt1(issue_cnt1), .err_cnt(err_cnt)
`endif
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [VLEN-1:0] actual,
                               input logic [VLEN-1:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Presents one beat on requester r and waits (bounded) for acceptance.
    // Returns at 1 unit after the accepting edge with valid dropped.
    task automatic applyStimulus(input int r, input logic [7:0] addr,
                                 input logic [7:0] gs, input logic last,
                                 input logic [VLEN-1:0] data, output int waits);
        if (r == 0) begin
            req0_valid = 1'b1; req0_rf_addr = addr; req0_group_size = gs;
            req0_last = last; req0_data = data;
        end else begin
            req1_valid = 1'b1; req1_rf_addr = addr; req1_group_size = gs;
            req1_last = last; req1_data = data;
        end
        #1;
        waits = 0;
        while (!(r == 0 ? req0_ready : req1_ready) && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 50) checkOutput("beat_timeout", 0, 1);
        else begin
            @(posedge clk); #1;
        end
        if (r == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk); #1;
    endtask

    int w;

    initial begin
        reset = 1'b1;
        req0_valid = 0; req0_is_store = 0; req0_wr_rf = 1; req0_last = 0;
        req0_rf_addr = 0; req0_group_size = 0; req0_data = '0;
        req1_valid = 0; req1_is_store = 1; req1_wr_rf = 0; req1_last = 0;
        req1_rf_addr = 0; req1_group_size = 0; req1_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_enable", dpi_enable, 0);
        checkOutput("rst_err_valid", err_valid, 0);
        checkOutput("rst_addr", dpi_rf_addr, 0);
        checkOutput("rst_data0", dpi_data_0, 0);
        checkOutput("rst_ready0", req0_ready, 0);
`ifdef VREG_DIFF_ARB_STATS_EN
        checkOutput("rst_cnt0", issue_cnt0, 0);
        checkOutput("rst_errcnt", err_cnt, 0);
`endif

        // Alternation: both hold single-beat size-1 packets
        req0_valid = 1; req0_rf_addr = 8'd3; req0_group_size = 8'd1;
        req0_last = 1; req0_data = 'h11;
        req1_valid = 1; req1_rf_addr = 8'd5; req1_group_size = 8'd1;
        req1_last = 1; req1_data = 'h22;
        #1;
        for (int c = 0; c < 6; c++) begin
            if (c % 2 == 0) begin
                checkOutput($sformatf("alt%0d_ready0", c), req0_ready, (c % 4 == 0));
                checkOutput($sformatf("alt%0d_ready1", c), req1_ready, (c % 4 == 2));
                checkOutput($sformatf("alt%0d_enable", c), dpi_enable, 0);
            end else begin
                checkOutput($sformatf("alt%0d_enable", c), dpi_enable, 1);
                checkOutput($sformatf("alt%0d_addr", c), dpi_rf_addr, (c % 4 == 1) ? 3 : 5);
                checkOutput($sformatf("alt%0d_data0", c), dpi_data_0, (c % 4 == 1) ? 'h11 : 'h22);
                checkOutput($sformatf("alt%0d_noready", c), {req0_ready, req1_ready}, 0);
            end
            if (c == 5) begin
                req0_valid = 0; req1_valid = 0;
            end
            idleCycle();
        end

        // req0: size 4 at v8, beats A0..A3
        for (int b = 0; b < 4; b++)
            applyStimulus(0, 8'd8, 8'd4, (b == 3), VLEN'('hA0 + b), w);
        checkOutput("g4_enable", dpi_enable, 1);
        checkOutput("g4_err", err_valid, 0);
        checkOutput("g4_addr", dpi_rf_addr, 8);
        checkOutput("g4_size", dpi_rf_group_size, 4);
        checkOutput("g4_is_store", dpi_is_store, 0);
        checkOutput("g4_wr_rf", dpi_wr_rf, 1);
        checkOutput("g4_seg0", dpi_data_0, 'hA0);
        checkOutput("g4_seg1", dpi_data_1, 'hA1);
        checkOutput("g4_seg2", dpi_data_2, 'hA2);
        checkOutput("g4_seg3", dpi_data_3, 'hA3);
        checkOutput("g4_seg4to7", dpi_data_4 | dpi_data_5 | dpi_data_6 | dpi_data_7, 0);
        idleCycle();
        checkOutput("g4_enable_once", dpi_enable, 0);

        // req1: size 2, three beats -> count mismatch
        for (int b = 0; b < 3; b++)
            applyStimulus(1, 8'd2, 8'd2, (b == 2), VLEN'('hB0 + b), w);
        checkOutput("cnt_err_valid", err_valid, 1);
        checkOutput("cnt_err_code", err_code, 2);
        checkOutput("cnt_enable", dpi_enable, 0);
        req0_valid = 1; req0_last = 1; req1_valid = 1;
        idleCycle();
        checkOutput("cnt_rr_ready0", req0_ready, 1);
        checkOutput("cnt_rr_ready1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        #1;

        // req0: misaligned header v6 size 4
        for (int b = 0; b < 4; b++)
            applyStimulus(0, 8'd6, 8'd4, (b == 3), VLEN'('hC0 + b), w);
        checkOutput("hdr_err_valid", err_valid, 1);
        checkOutput("hdr_err_code", err_code, 1);
        checkOutput("hdr_enable", dpi_enable, 0);
        idleCycle();

        // req0: size 8 with 10 beats -> overrun, tail drained
        for (int b = 0; b < 10; b++) begin
            applyStimulus(0, 8'd0, 8'd8, (b == 9), VLEN'('hE0 + b), w);
            if (b >= 8) checkOutput($sformatf("drain_beat%0d_nowait", b + 1), w, 0);
            if (b == 8) checkOutput("drain_busy", busy, 1);
        end
        checkOutput("ovr_err_valid", err_valid, 1);
        checkOutput("ovr_err_code", err_code, 3);
        checkOutput("ovr_enable", dpi_enable, 0);
        idleCycle();
`ifdef VREG_DIFF_ARB_STATS_EN
        checkOutput("stat_cnt0", issue_cnt0, 3);
        checkOutput("stat_cnt1", issue_cnt1, 1);
        checkOutput("stat_errcnt", err_cnt, 3);
`endif

        // Reset mid-packet after two beats (rr currently favours req1)
        applyStimulus(0, 8'd4, 8'd4, 1'b0, VLEN'('hF0), w);
        applyStimulus(0, 8'd4, 8'd4, 1'b0, VLEN'('hF1), w);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_enable", dpi_enable, 0);
        checkOutput("mid_rst_data1", dpi_data_1, 0);
`ifdef VREG_DIFF_ARB_STATS_EN
        checkOutput("mid_rst_cnt0", issue_cnt0, 0);
        checkOutput("mid_rst_cnt1", issue_cnt1, 0);
        checkOutput("mid_rst_errcnt", err_cnt, 0);
`endif
        req0_valid = 1; req0_rf_addr = 8'd7; req0_group_size = 8'd1;
        req0_last = 1; req0_data = 'hD0;
        req1_valid = 1; req1_rf_addr = 8'd9; req1_group_size = 8'd1;
        req1_last = 1; req1_data = 'hD1;
        #1;
        checkOutput("post_rst_ready0", req0_ready, 1);
        checkOutput("post_rst_ready1", req1_ready, 0);
        idleCycle();
        req0_valid = 0; req1_valid = 0;
        checkOutput("post_rst_enable", dpi_enable, 1);
        checkOutput("post_rst_addr", dpi_rf_addr, 7);
        checkOutput("post_rst_data0", dpi_data_0, 'hD0);
        checkOutput("post_rst_data1", dpi_data_1, 0);
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
